// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - producer-side FIFO port bundle for uart_tx_buffered
interface uart_tx_buffered_if #(
   parameter int AW = 4
);
   logic          WrEn;
   logic [7:0]    WrData;
   logic          Full;
   logic          Empty;
   logic [AW:0]   Count;
   logic          Overflow;

   // producer drives the write strobe and byte, observes occupancy
   modport master (
      output WrEn, WrData,
      input  Full, Empty, Count, Overflow
   );

   // transmitter accepts bytes and reports occupancy
   modport slave (
      input  WrEn, WrData,
      output Full, Empty, Count, Overflow
   );
endinterface

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered UART transmitter: byte FIFO feeding an 8N1 serializer
module uart_tx_buffered #(
   parameter int DEPTH      = 16,
   parameter int AW         = 4,
   parameter int OVERSAMPLE = 16
)(
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Tick,
   input  logic [3:0]         NBits,
   uart_tx_buffered_if.slave  wr,
   output logic               Tx,
   output logic               TxBusy,
   output logic               TxDone
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   localparam int            TW         = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   countNext;
   logic          push;
   logic          pop;

   logic [1:0]    state;
   logic [TW-1:0] tickCnt;
   logic [3:0]    bitCnt;
   logic [3:0]    nbitsLat;
   logic [7:0]    shiftReg;
   logic          bitEnd;
   logic          nbitsLegal;

   // A write while full is dropped even if the serializer pops in the same cycle,
   // so the full flag alone gates acceptance.
   assign push       = wr.WrEn && !wr.Full;
   assign pop        = (state == IDLE) && !wr.Empty;
   assign bitEnd     = Tick && (tickCnt == TICK_LAST);
   assign nbitsLegal = (NBits >= 4'd5) && (NBits <= 4'd8);

   // Occupancy after this cycle's push/pop; a simultaneous pair leaves it unchanged
   always_comb begin
      countNext = wr.Count;
      if (push && !pop) begin
         countNext = wr.Count + (AW+1)'(1);
      end else if (pop && !push) begin
         countNext = wr.Count - (AW+1)'(1);
      end
   end

   // FIFO storage; contents need no reset because Count guards every read
   always_ff @(posedge Clk) begin
      if (push) begin
         mem[wptr] <= wr.WrData;
      end
   end

   // Pointers and registered status flags; pointers wrap naturally at DEPTH
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wptr        <= '0;
         rptr        <= '0;
         wr.Count    <= '0;
         wr.Empty    <= 1'b1;
         wr.Full     <= 1'b0;
         wr.Overflow <= 1'b0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         wr.Count    <= countNext;
         wr.Empty    <= (countNext == '0);
         wr.Full     <= (countNext == FULL_COUNT);
         wr.Overflow <= wr.WrEn && wr.Full;
      end
   end

   // Serializer: start bit, NBits data bits LSB first, one stop bit, paced by Tick
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state    <= IDLE;
         Tx       <= 1'b1;
         TxBusy   <= 1'b0;
         TxDone   <= 1'b0;
         tickCnt  <= '0;
         bitCnt   <= '0;
         nbitsLat <= 4'd8;
         shiftReg <= '0;
      end else begin
         TxDone <= 1'b0;
         if (Tick) begin
            tickCnt <= bitEnd ? '0 : tickCnt + 1'b1;
         end
         case (state)
            IDLE: begin
               Tx      <= 1'b1;
               tickCnt <= '0;
               if (pop) begin
                  shiftReg <= mem[rptr];
                  nbitsLat <= nbitsLegal ? NBits : 4'd8;
                  bitCnt   <= '0;
                  Tx       <= 1'b0;
                  TxBusy   <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               if (bitEnd) begin
                  Tx    <= shiftReg[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (bitEnd) begin
                  if (bitCnt == nbitsLat - 4'd1) begin
                     Tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     shiftReg <= shiftReg >> 1;
                     Tx       <= shiftReg[1];
                     bitCnt   <= bitCnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (bitEnd) begin
                  TxDone <= 1'b1;
                  TxBusy <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - directed self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

   logic       Clk;
   logic       Rst;
   logic       Tick;
   logic [3:0] NBits;
   logic       Tx;
   logic       TxBusy;
   logic       TxDone;

   int nTests = 0;
   int nFail  = 0;
   int tickMode = 0;
   int tickDiv = 0;

   logic [7:0] rxQ[$];
   logic [7:0] sentQ[$];
   int         rxBits = 8;
   int         rxState = 0;
   int         rxCnt = 0;
   int         rxIdx = 0;
   logic [7:0] rxData = '0;
   int         rxFrameErr = 0;

   uart_tx_buffered_if #(.AW(4)) wrIf();

   uart_tx_buffered #(.DEPTH(16), .AW(4), .OVERSAMPLE(16)) dut (
      .Clk    (Clk),
      .Rst    (Rst),
      .Tick   (Tick),
      .NBits  (NBits),
      .wr     (wrIf),
      .Tx     (Tx),
      .TxBusy (TxBusy),
      .TxDone (TxDone)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // tickMode 0: no ticks, 1: one tick every 4 clocks, 2: tick held high
   initial begin
      Tick = 1'b0;
      forever begin
         @(negedge Clk);
         tickDiv = (tickDiv + 1) % 4;
         Tick = (tickMode == 2) ? 1'b1 : ((tickMode == 1) ? (tickDiv == 0) : 1'b0);
      end
   end

   // Reference receiver: 16x oversampled, samples mid-bit, same Tick as the DUT
   initial begin
      forever begin
         @(posedge Clk);
         #1;
         if (Rst) begin
            rxState = 0;
         end else if (Tick) begin
            case (rxState)
               0: if (Tx == 1'b0) begin rxCnt = 0; rxState = 1; end
               1: begin
                  rxCnt++;
                  if (rxCnt == 8) begin
                     rxCnt = 0;
                     if (Tx == 1'b0) begin rxState = 2; rxIdx = 0; rxData = '0; end
                     else rxState = 0;
                  end
               end
               2: begin
                  rxCnt++;
                  if (rxCnt == 16) begin
                     rxCnt = 0;
                     rxData[rxIdx] = Tx;
                     rxIdx++;
                     if (rxIdx == rxBits) rxState = 3;
                  end
               end
               default: begin
                  rxCnt++;
                  if (rxCnt == 16) begin
                     if (Tx !== 1'b1) rxFrameErr++;
                     rxQ.push_back(rxData);
                     rxState = 0;
                  end
               end
            endcase
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: observed no end of test, expected finish before limit");
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      wrIf.WrEn   = 1'b1;
      wrIf.WrData = b;
      cyc(1);
      wrIf.WrEn   = 1'b0;
   endtask

   task automatic waitRx(input int n, input int budget);
      int k;
      k = 0;
      while (rxQ.size() < n && k < budget) begin cyc(1); k++; end
      check("rx_count", rxQ.size(), n);
   endtask

   task automatic waitDone(input string tag, input int budget);
      int k;
      k = 0;
      while (TxDone !== 1'b1 && k < budget) begin cyc(1); k++; end
      check(tag, TxDone, 1);
   endtask

   task automatic measureFrame(output int busyLen, output int lowLen);
      int guard;
      busyLen = 0;
      lowLen  = 0;
      guard   = 0;
      while (!TxBusy && guard < 50) begin cyc(1); guard++; end
      while (TxBusy && guard < 3000) begin
         busyLen++;
         if (!Tx) lowLen++;
         cyc(1);
         guard++;
      end
   endtask

   function automatic logic [7:0] pat4(input int i);
      return 8'(i * 37 + 5);
   endfunction

   initial begin
      logic [8:0] expBits;
      int         startLen;
      int         doneSeen;
      int         busyLen;
      int         lowLen;
      logic [7:0] b;

      Rst         = 1'b1;
      NBits       = 4'd8;
      wrIf.WrEn   = 1'b0;
      wrIf.WrData = '0;
      tickMode    = 0;
      cyc(2);

      // reset state
      check("rst_empty", wrIf.Empty, 1);
      check("rst_full", wrIf.Full, 0);
      check("rst_count", wrIf.Count, 0);
      check("rst_overflow", wrIf.Overflow, 0);
      check("rst_tx", Tx, 1);
      check("rst_busy", TxBusy, 0);
      check("rst_done", TxDone, 0);
      Rst = 1'b0;
      cyc(2);

      // single byte 0xA5, one tick per 4 clocks, 64 clocks per bit
      tickMode = 1;
      rxBits   = 8;
      rxQ.delete();
      push(8'hA5);
      check("lat_empty", wrIf.Empty, 0);
      check("lat_count", wrIf.Count, 1);
      check("lat_tx_high", Tx, 1);
      cyc(1);
      check("lat_tx_low", Tx, 0);
      check("lat_busy", TxBusy, 1);
      check("lat_popped", wrIf.Empty, 1);
      startLen = 1;
      while (Tx == 1'b0 && startLen < 200) begin cyc(1); startLen++; end
      check("start_len_ok", (startLen >= 60 && startLen <= 68), 1);
      expBits = 9'b1_1010_0101;
      cyc(32);
      check("a5_bit0", Tx, expBits[0]);
      for (int i = 1; i < 9; i++) begin
         cyc(64);
         check("a5_bit", Tx, expBits[i]);
      end
      cyc(31);
      check("a5_done_early", TxDone, 0);
      check("a5_busy_stop", TxBusy, 1);
      cyc(1);
      check("a5_done", TxDone, 1);
      check("a5_busy_drop", TxBusy, 0);
      cyc(1);
      check("a5_done_pulse", TxDone, 0);
      check("a5_rx_n", rxQ.size(), 1);
      check("a5_rx", rxQ[0], 8'hA5);

      // reset in the middle of a frame
      tickMode = 2;
      push(8'h00);
      push(8'h11);
      push(8'h22);
      cyc(20);
      check("mid_busy", TxBusy, 1);
      check("mid_count", wrIf.Count, 2);
      Rst = 1'b1;
      #1;
      check("mid_rst_tx", Tx, 1);
      check("mid_rst_busy", TxBusy, 0);
      check("mid_rst_count", wrIf.Count, 0);
      check("mid_rst_empty", wrIf.Empty, 1);
      cyc(2);
      Rst = 1'b0;
      doneSeen = 0;
      for (int i = 0; i < 300; i++) begin
         cyc(1);
         if (TxDone || TxBusy) doneSeen++;
      end
      check("mid_rst_quiet", doneSeen, 0);
      rxQ.delete();

      // burst: fill to 16 behind an in-flight frame, then overflow twice
      push(8'h00);
      cyc(1);
      for (int i = 1; i <= 16; i++) begin
         push(8'(i));
         if (i == 15) check("burst_not_full", wrIf.Full, 0);
      end
      check("burst_full", wrIf.Full, 1);
      check("burst_count16", wrIf.Count, 16);
      push(8'h11);
      check("ovf_pulse", wrIf.Overflow, 1);
      check("ovf_count", wrIf.Count, 16);
      cyc(1);
      check("ovf_clear", wrIf.Overflow, 0);
      waitDone("burst_done0", 400);
      check("pop_cycle_full", wrIf.Full, 1);
      push(8'h12);
      check("ovf_with_pop", wrIf.Overflow, 1);
      check("ovf_pop_count", wrIf.Count, 15);
      waitRx(17, 17 * 200);
      cyc(30);
      check("burst_empty", wrIf.Empty, 1);
      check("burst_idle", TxBusy, 0);
      for (int i = 0; i < 17; i++) begin
         check("burst_order", rxQ[i], 8'(i));
      end
      rxQ.delete();

      // simultaneous push and pop at Count=3, then 20 bytes through the wrap
      for (int i = 0; i < 4; i++) push(pat4(i));
      check("pp_count3", wrIf.Count, 3);
      waitDone("pp_done", 400);
      push(pat4(4));
      check("pp_count_hold", wrIf.Count, 3);
      for (int i = 5; i < 20; i++) begin
         for (int j = 0; j < 2000 && wrIf.Full; j++) cyc(1);
         push(pat4(i));
      end
      waitRx(20, 20 * 200);
      for (int i = 0; i < 20; i++) begin
         check("wrap_data", rxQ[i], pat4(i));
      end
      cyc(30);
      rxQ.delete();

      // 5-bit frames with a mid-frame NBits change, and NBits=0 as 8 bits
      NBits  = 4'd5;
      rxBits = 5;
      push(8'hFF);
      cyc(1);
      NBits = 4'd8;
      measureFrame(busyLen, lowLen);
      check("n5_busy_len", busyLen, 112);
      check("n5_low_len", lowLen, 16);
      check("n5_rx", rxQ[0], 8'h1F);
      cyc(5);
      rxQ.delete();
      NBits  = 4'd0;
      rxBits = 8;
      push(8'h00);
      measureFrame(busyLen, lowLen);
      check("n0_busy_len", busyLen, 160);
      check("n0_low_len", lowLen, 144);
      check("n0_rx_n", rxQ.size(), 1);
      NBits = 4'd8;
      cyc(5);
      rxQ.delete();

      // 200 random bytes decoded by the reference receiver
      rxFrameErr = 0;
      for (int i = 0; i < 200; i++) begin
         b = 8'($urandom_range(0, 255));
         for (int j = 0; j < 2000 && wrIf.Full; j++) cyc(1);
         push(b);
         sentQ.push_back(b);
      end
      waitRx(200, 200 * 200);
      for (int i = 0; i < 200; i++) begin
         check("rand_data", rxQ[i], sentQ[i]);
      end
      check("rand_framing", rxFrameErr, 0);
      cyc(30);
      check("final_empty", wrIf.Empty, 1);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
